// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, FSM states and multi-cycle latency for alu_seq
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  // Accept-to-out_valid edges for MUL/DIV: SETUP + WIDTH ITER steps + FIX.
  function automatic int muldiv_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/alu_seq_mul_div_iter.sv
// rtl/alu_seq_mul_div_iter.sv - iterative signed shift-add multiply / restoring divide
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               setup_en,
  input  logic               iter_en,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, mb_q, hi_q, lo_q;
  logic             div_q, sa_q, sb_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // hi_q is the product high half (MUL) or partial remainder (DIV); lo_q shifts out
  // multiplier bits (MUL) or dividend bits in exchange for quotient bits (DIV).
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mb_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      mb_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        div_q <= op_div;
      end
      if (setup_en) begin
        sa_q  <= a_q[WIDTH-1];
        sb_q  <= b_q[WIDTH-1];
        mb_q  <= b_q[WIDTH-1] ? ('0 - b_q) : b_q;
        lo_q  <= a_q[WIDTH-1] ? ('0 - a_q) : a_q;
        hi_q  <= '0;
        cnt_q <= '0;
      end
      if (iter_en) begin
        cnt_q <= cnt_q + 1'b1;
        if (div_q) begin
          hi_q <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          hi_q <= mul_sum[WIDTH:1];
          lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
    end
  end

  assign done = iter_en && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    prod        = {hi_q, lo_q};
    quot        = (sa_q ^ sb_q) ? ('0 - lo_q) : lo_q;
    rem         = sa_q ? ('0 - hi_q) : hi_q;
    result      = '0;
    div_by_zero = 1'b0;
    if (div_q) begin
      if (b_q == '0) begin
        result      = {a_q, {WIDTH{1'b1}}};
        div_by_zero = 1'b1;
      end else begin
        result = {rem, quot};
      end
    end else begin
      result = (sa_q ^ sb_q) ? ('0 - prod) : prod;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: single-cycle op mux plus iterative MUL/DIV FSM
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op_select,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state_q;
  logic [2*WIDTH-1:0] result_q;
  logic               dbz_q;

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   single_res;
  logic               is_md, md_start, md_done, md_dbz;
  logic [2*WIDTH-1:0] md_result;

  assign sh       = b[SHW-1:0];
  assign is_md    = (op_select == OP_MUL) || (op_select == OP_DIV);
  assign md_start = (state_q == ST_IDLE) && in_valid && is_md;

  always_comb begin
    // Rotates fall out of a doubled operand, which also handles sh == 0 cleanly.
    rot_r      = {a, a} >> sh;
    rot_l      = {a, a} << sh;
    single_res = '0;
    case (op_select)
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_NEG:  single_res = '0 - b;
      OP_NOT:  single_res = ~b;
      OP_SHR:  single_res = a >> sh;
      OP_SHRA: single_res = $signed(a) >>> sh;
      OP_SHL:  single_res = a << sh;
      OP_ROR:  single_res = rot_r[WIDTH-1:0];
      OP_ROL:  single_res = rot_l[2*WIDTH-1:WIDTH];
      default: single_res = '0;
    endcase
  end

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (md_start),
    .op_div      (op_select == OP_DIV),
    .a           (a),
    .b           (b),
    .setup_en    (state_q == ST_SETUP),
    .iter_en     (state_q == ST_ITER),
    .done        (md_done),
    .result      (md_result),
    .div_by_zero (md_dbz)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_md) begin
              state_q <= ST_SETUP;
            end else begin
              result_q <= {{WIDTH{1'b0}}, single_res};
              dbz_q    <= 1'b0;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_SETUP: state_q <= ST_ITER;
        ST_ITER:  if (md_done) state_q <= ST_FIX;
        ST_FIX: begin
          result_q <= md_result;
          dbz_q    <= md_dbz;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            dbz_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
